// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO pacing single-cycle flushes into uart_tx
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 in_byte,
  input  logic                       in_valid,
  input  logic                       tx_busy,
  output logic [7:0]                 tx_byte,
  output logic                       tx_flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_IDLE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_nxt;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [7:0]      mem [DEPTH];
  logic            pop;
  logic            push;
  logic            drop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A slot freed by a same-cycle pop can take the incoming byte even when full.
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_byte;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // FSM state, busy-wait timer and the registered byte/flush to uart_tx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      tx_byte  <= 8'h00;
      tx_flush <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      tx_flush <= pop;
      if (pop) begin
        tx_byte <= mem[rd_ptr];
      end
    end
  end

  // Next-state logic: pop from IDLE, then follow tx_busy up and back down,
  // giving up on the rise after BUSY_TIMEOUT cycles.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          timer_nxt = '0;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_IDLE;
        end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      WAIT_IDLE: begin
        if (!tx_busy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with a uart_tx busy model
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int BT    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_valid = 1'b0;
  logic       tx_busy;
  logic [7:0] tx_byte;
  logic       tx_flush;
  logic [2:0] count;
  logic       empty;
  logic       full;
  logic       overflow;

  logic       bfm_en = 1'b0;
  logic       bfm_busy = 1'b0;
  logic       force_busy = 1'b0;
  int         bfm_left = 0;

  int         n_assert = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         flush_cnt = 0;
  int         f0;
  logic       prev_flush = 1'b0;
  logic [7:0] exp_q [$];
  int         fl_cyc [$];

  assign tx_busy = bfm_busy | force_busy;

  uart_tx_fifo #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_byte  (in_byte),
    .in_valid (in_valid),
    .tx_busy  (tx_busy),
    .tx_byte  (tx_byte),
    .tx_flush (tx_flush),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // uart_tx model: busy for 20 cycles starting the cycle after a flush
  always @(posedge clk) begin
    #1;
    if (bfm_left > 0) begin
      bfm_busy = 1'b1;
      bfm_left--;
    end else begin
      bfm_busy = 1'b0;
    end
  end

  // output monitor: compare every flushed byte against the scoreboard
  always @(negedge clk) begin
    if (rst_n && tx_flush) begin
      flush_cnt++;
      fl_cyc.push_back(cyc);
      if (bfm_en) bfm_left = 20;
      check("flush_not_back_to_back", {31'd0, prev_flush}, 32'd0);
      check("scoreboard_has_entry", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check("tx_byte_order", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
    end
    prev_flush = tx_flush;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] b, input bit expect_out);
    in_byte  = b;
    in_valid = 1'b1;
    if (expect_out) exp_q.push_back(b);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    force_busy = 1'b0;
    bfm_en     = 1'b0;
    bfm_left   = 0;
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input int max_cyc, input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max_cyc) begin
      tick();
      k++;
    end
    check(tag, exp_q.size(), 32'd0);
    repeat (30) tick();
  endtask

  initial begin
    // reset state
    #2;
    check("rst_tx_byte", {24'd0, tx_byte}, 32'h00);
    check("rst_tx_flush", {31'd0, tx_flush}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    do_reset();

    // single byte: flush two cycles after the push, count back to 0
    drive(8'hA5, 1'b1);
    check("single_n1_flush", {31'd0, tx_flush}, 32'd0);
    check("single_n1_count", {29'd0, count}, 32'd1);
    tick();
    check("single_n2_flush", {31'd0, tx_flush}, 32'd1);
    check("single_n2_byte", {24'd0, tx_byte}, 32'hA5);
    check("single_n2_count", {29'd0, count}, 32'd0);
    tick();
    check("single_n3_flush", {31'd0, tx_flush}, 32'd0);
    check("single_n3_hold", {24'd0, tx_byte}, 32'hA5);
    wait_drain(50, "single_drain");

    // burst against the busy model
    do_reset();
    bfm_en = 1'b1;
    fl_cyc.delete();
    f0 = flush_cnt;
    for (int i = 1; i <= 5; i++) drive(8'(i), 1'b1);
    wait_drain(300, "burst_drain");
    check("burst_flushes", flush_cnt - f0, 32'd5);
    check("burst_overflow", {31'd0, overflow}, 32'd0);
    for (int i = 1; i < fl_cyc.size(); i++)
      check("burst_gap", {31'd0, (fl_cyc[i] - fl_cyc[i-1] >= 22) && (fl_cyc[i] - fl_cyc[i-1] <= 23)}, 32'd1);

    // fill to full and overflow with busy held
    do_reset();
    force_busy = 1'b1;
    f0 = flush_cnt;
    for (int k = 1; k <= 6; k++) begin
      drive(8'(8'h30 + k), k <= DEPTH);
      check("fill_count", {29'd0, count}, (k < DEPTH) ? k : DEPTH);
      check("fill_full", {31'd0, full}, {31'd0, k >= DEPTH});
      check("fill_overflow", {31'd0, overflow}, {31'd0, k >= DEPTH + 1});
    end
    check("fill_no_flush", flush_cnt - f0, 32'd0);
    bfm_en = 1'b1;
    force_busy = 1'b0;
    wait_drain(300, "fill_drain");
    check("fill_flushes", flush_cnt - f0, 32'd4);

    // push at full with a same-cycle pop
    do_reset();
    force_busy = 1'b1;
    f0 = flush_cnt;
    for (int k = 0; k < DEPTH; k++) drive(8'(8'h11 * (k + 1)), 1'b1);
    check("pp_count_before", {29'd0, count}, 32'd4);
    force_busy = 1'b0;
    bfm_en = 1'b1;
    drive(8'hEE, 1'b1);
    check("pp_count", {29'd0, count}, 32'd4);
    check("pp_full", {31'd0, full}, 32'd1);
    check("pp_overflow", {31'd0, overflow}, 32'd0);
    check("pp_flush", {31'd0, tx_flush}, 32'd1);
    wait_drain(300, "pp_drain");
    check("pp_flushes", flush_cnt - f0, 32'd5);

    // timeout: tx_busy never rises
    do_reset();
    fl_cyc.delete();
    drive(8'hC1, 1'b1);
    drive(8'hC2, 1'b1);
    wait_drain(100, "timeout_drain");
    check("timeout_flushes", fl_cyc.size(), 32'd2);
    if (fl_cyc.size() == 2) check("timeout_gap", fl_cyc[1] - fl_cyc[0], BT + 1);

    // asynchronous reset while waiting for busy to drop
    do_reset();
    bfm_en = 1'b1;
    for (int k = 0; k < 4; k++) drive(8'(8'h70 + k), 1'b1);
    repeat (8) tick();
    check("ar_count_before", {29'd0, count}, 32'd3);
    check("ar_busy_before", {31'd0, tx_busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_count", {29'd0, count}, 32'd0);
    check("ar_empty", {31'd0, empty}, 32'd1);
    check("ar_flush", {31'd0, tx_flush}, 32'd0);
    check("ar_overflow", {31'd0, overflow}, 32'd0);
    exp_q.delete();
    f0 = flush_cnt;
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("ar_no_flush", flush_cnt - f0, 32'd0);
    drive(8'h5A, 1'b1);
    wait_drain(100, "ar_new_drain");
    check("ar_new_flush", flush_cnt - f0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
